// File: rtl/evfilt_pkg.sv
// Shared types and helpers for the OR-line event filter.
// Holds the filter state encoding and parameter checks.
package evfilt_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } filt_state_e;

  localparam int FILTER_CYCLES_MIN = 1;

  function automatic int evfilt_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // fc fits the counter iff 1 <= fc <= 2**w
  function automatic bit evfilt_range_ok(
    input int fc,
    input int w
  );
    return (fc >= FILTER_CYCLES_MIN) &&
           (evfilt_clog2(fc) <= w);
  endfunction

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Both stages reset to INIT; no enable.
module sync2_ff #(
  parameter logic INIT = 1'b0
) (
  input  logic C,
  input  logic CLRB,
  input  logic D,
  output logic Q
);

  logic s1;
  logic s2;

  always_ff @(posedge C or negedge CLRB) begin
    if (!CLRB) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= D;
      s2 <= s1;
    end
  end

  assign Q = s2;

endmodule

// File: rtl/or_event_filter.sv
// De-glitches a synchronized OR-line level and counts its rises.
// Emits registered level, edge pulses and a sticky saturating count.
module or_event_filter
  import evfilt_pkg::*;
#(
  parameter int   FILTER_CYCLES = 8,
  parameter int   FILTER_W      = 4,
  parameter int   CNT_W         = 8,
  parameter logic INIT          = 1'b0
) (
  input  logic             C,
  input  logic             CLRB,
  input  logic             I,
  input  logic             CE,
  input  logic             CNT_CLR,
  output logic             Q,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] CNT,
  output logic             CNT_SAT
);

  localparam bit RANGE_OK =
    evfilt_range_ok(FILTER_CYCLES, FILTER_W);

  generate
    if (!RANGE_OK) begin : g_bad_range
      $error("or_event_filter: FILTER_CYCLES out of range");
    end
  endgenerate

  localparam logic [FILTER_W-1:0] LAST =
    FILTER_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PEN =
    CNT_MAX - CNT_W'(1);

  logic                s2;
  logic                q;
  logic                rise;
  logic                fall;
  logic [FILTER_W-1:0] fcnt;
  filt_state_e         state;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_sat;

  logic match;
  logic done;
  logic step;
  logic cnt_inc;

  sync2_ff #(
    .INIT (INIT)
  ) u_sync (
    .C    (C),
    .CLRB (CLRB),
    .D    (I),
    .Q    (s2)
  );

  // Exclusive decode so the FSM case below is truly unique
  assign match   = (s2 == q);
  assign done    = !match && (fcnt == LAST);
  assign step    = !match && (fcnt != LAST);
  assign cnt_inc = CE && done && s2 && !cnt_sat;

  always_ff @(posedge C or negedge CLRB) begin
    if (!CLRB) begin
      q     <= INIT;
      fcnt  <= '0;
      state <= STABLE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (CE) begin
        unique case (1'b1)
          match: begin
            fcnt  <= '0;
            state <= STABLE;
          end
          done: begin
            q     <= s2;
            fcnt  <= '0;
            state <= STABLE;
            rise  <= s2;
            fall  <= !s2;
          end
          step: begin
            if (state == STABLE) begin
              fcnt <= FILTER_W'(1);
            end else begin
              fcnt <= fcnt + FILTER_W'(1);
            end
            state <= SETTLE;
          end
          default: begin
            fcnt  <= '0;
            state <= STABLE;
          end
        endcase
      end
    end
  end

  // Clear beats a coincident increment; that event is dropped
  always_ff @(posedge C or negedge CLRB) begin
    if (!CLRB) begin
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else if (CNT_CLR) begin
      cnt     <= '0;
      cnt_sat <= 1'b0;
    end else if (cnt_inc) begin
      cnt     <= cnt + CNT_W'(1);
      cnt_sat <= (cnt == CNT_PEN);
    end
  end

  assign Q       = q;
  assign RISE    = rise;
  assign FALL    = fall;
  assign CNT     = cnt;
  assign CNT_SAT = cnt_sat;

endmodule

// File: tb/tb_or_event_filter.sv
// Directed bench for or_event_filter: latency, glitches, CE,
// saturation, clear priority and mid-settle reset.
module tb_or_event_filter;

  logic       C = 1'b0;
  logic       CLRB;
  logic       I;
  logic       CE;
  logic       CNT_CLR;
  logic       q;
  logic       rise;
  logic       fall;
  logic [7:0] cnt;
  logic       sat;

  logic       i2;
  logic       ce2;
  logic       clr2;
  logic       q2;
  logic       rise2;
  logic       fall2;
  logic [1:0] cnt2;
  logic       sat2;

  int n_vec = 0;
  int n_bad = 0;

  or_event_filter #(
    .FILTER_CYCLES (8),
    .FILTER_W      (4),
    .CNT_W         (8),
    .INIT          (1'b0)
  ) u_dut (
    .C       (C),
    .CLRB    (CLRB),
    .I       (I),
    .CE      (CE),
    .CNT_CLR (CNT_CLR),
    .Q       (q),
    .RISE    (rise),
    .FALL    (fall),
    .CNT     (cnt),
    .CNT_SAT (sat)
  );

  or_event_filter #(
    .FILTER_CYCLES (3),
    .FILTER_W      (2),
    .CNT_W         (2),
    .INIT          (1'b0)
  ) u_sat (
    .C       (C),
    .CLRB    (CLRB),
    .I       (i2),
    .CE      (ce2),
    .CNT_CLR (clr2),
    .Q       (q2),
    .RISE    (rise2),
    .FALL    (fall2),
    .CNT     (cnt2),
    .CNT_SAT (sat2)
  );

  always #5 C = ~C;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge C);
    #1;
  endtask

  task automatic chk_main(
    input string tag,
    input logic  eq,
    input logic  er,
    input logic  ef
  );
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".rise"}, 32'(rise), 32'(er));
    chk({tag, ".fall"}, 32'(fall), 32'(ef));
  endtask

  int exp_cnt2 [5];

  initial begin
    exp_cnt2 = '{1, 2, 3, 3, 3};
    CLRB    = 1'b1;
    I       = 1'b0;
    CE      = 1'b1;
    CNT_CLR = 1'b0;
    i2      = 1'b0;
    ce2     = 1'b1;
    clr2    = 1'b0;
    #2 CLRB = 1'b0;
    tick(3);
    chk("rst.q", 32'(q), 0);
    chk("rst.cnt", 32'(cnt), 0);
    chk("rst.sat", 32'(sat), 0);
    chk("rst.rise", 32'(rise), 0);
    chk("rst.fall", 32'(fall), 0);
    chk("rst.cnt2", 32'(cnt2), 0);
    CLRB = 1'b1;

    // quiet after release
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      chk_main("idle", 1'b0, 1'b0, 1'b0);
      chk("idle.cnt", 32'(cnt), 0);
    end

    // basic rise: update at edge 10
    I = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick(1);
      chk_main("rise", n >= 10, n == 10, 1'b0);
      chk("rise.cnt", 32'(cnt), (n >= 10) ? 1 : 0);
    end

    I = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      chk_main("fall", n < 10, 1'b0, n == 10);
    end
    chk("fall.cnt", 32'(cnt), 1);

    // 7-cycle glitch is rejected
    I = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      chk_main("g7", 1'b0, 1'b0, 1'b0);
      if (n == 7) I = 1'b0;
    end
    chk("g7.cnt", 32'(cnt), 1);

    // 8-cycle pulse passes: rise@10, fall@18
    I = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      tick(1);
      chk_main("g8", (n >= 10) && (n < 18), n == 10, n == 18);
      if (n == 8) I = 1'b0;
    end
    chk("g8.cnt", 32'(cnt), 2);

    // CE low on edges 6..8 delays update to edge 13
    I = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick(1);
      chk_main("ce", n >= 13, n == 13, 1'b0);
      if (n == 5) CE = 1'b0;
      if (n == 8) CE = 1'b1;
    end
    chk("ce.cnt", 32'(cnt), 3);
    I = 1'b0;
    tick(12);
    chk("ce.back", 32'(q), 0);

    // reset with FCNT=5 mid-settle
    I = 1'b1;
    tick(7);
    #1 CLRB = 1'b0;
    #1;
    chk("arst.q", 32'(q), 0);
    chk("arst.cnt", 32'(cnt), 0);
    tick(2);
    CLRB = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick(1);
      chk_main("rel", n >= 10, n == 10, 1'b0);
      chk("rel.cnt", 32'(cnt), (n >= 10) ? 1 : 0);
    end

    // saturation on CNT_W=2, FILTER_CYCLES=3
    for (int k = 0; k < 5; k++) begin
      i2 = 1'b1;
      tick(6);
      chk("sat.cnt", 32'(cnt2), 32'(exp_cnt2[k]));
      chk("sat.flag", 32'(sat2), (k >= 2) ? 1 : 0);
      i2 = 1'b0;
      tick(6);
    end

    // clear coincident with the 6th rise
    i2 = 1'b1;
    tick(4);
    clr2 = 1'b1;
    tick(1);
    clr2 = 1'b0;
    chk("clr.q", 32'(q2), 1);
    chk("clr.rise", 32'(rise2), 1);
    chk("clr.cnt", 32'(cnt2), 0);
    chk("clr.sat", 32'(sat2), 0);
    tick(1);
    chk("clr.hold", 32'(cnt2), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
